// File: rtl/home_event_decoder.sv
// home_event_decoder: validates home-monitor poll frames, stretches pulses into actuator drives, queues new activations.
// Optional ERR_COUNT_EN adds a saturating malformed-frame counter on err_count.
module home_event_decoder #(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 4,
  parameter int FIFO_DEPTH  = 4
`ifdef ERR_COUNT_EN
  , parameter int ERR_W     = 8
`endif
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [5:0]                    in_bus,
  input  logic [2:0]                    in_code,
  input  logic                          evt_ready,
  input  logic                          ovf_clr,
  output logic                          fdoor_act,
  output logic                          rdoor_act,
  output logic                          alarm_act,
  output logic                          win_act,
  output logic                          heater_act,
  output logic                          cooler_act,
  output logic                          evt_valid,
  output logic [2:0]                    evt_code,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          evt_ovf,
  output logic                          frame_err
`ifdef ERR_COUNT_EN
  , output logic [ERR_W-1:0]            err_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [5:0]        exp_bus;
  logic              is_evt, frame_ok;
  logic [5:0]        hit, kill, act;
  logic [HOLD_W-1:0] cnt_q [6];
  logic [HOLD_W-1:0] cnt_d [6];
  logic [2:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, ferr_q;
  logic              push, pop, full, wr, drop;
  // Channel c (0 = fdoor .. 5 = cooler) carries code c+1 on bus bit 5-c
  always_comb begin
    exp_bus  = 6'b100000 >> (in_code - 3'd1);
    is_evt   = in_code != 3'd0 && in_code != 3'd7 && in_bus == exp_bus;
    frame_ok = is_evt || (in_code == 3'd0 && in_bus == 6'd0);
    for (int c = 0; c < 6; c++) begin
      hit[c] = is_evt && in_code == 3'(c + 1);
      act[c] = cnt_q[c] != '0;
    end
  end
  // Heater and cooler cancel each other's hold
  assign kill = {hit[4], hit[5], 4'b0000};
  always_comb begin
    for (int c = 0; c < 6; c++)
      cnt_d[c] = hit[c] ? HOLD_W'(HOLD_CYCLES) : (kill[c] || !act[c]) ? '0 : cnt_q[c] - HOLD_W'(1);
  end
  always_comb begin
    push    = |(hit & ~act);
    pop     = count_q != '0 && evt_ready;
    full    = count_q == CW'(FIFO_DEPTH);
    wr      = push && (!full || pop);
    drop    = push && full && !pop;
    wp_d    = wr ? wp_q + AW'(1) : wp_q;
    rp_d    = pop ? rp_q + AW'(1) : rp_q;
    count_d = count_q + CW'(wr) - CW'(pop);
    ovf_d   = (ovf_q && !ovf_clr) || drop;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int c = 0; c < 6; c++) cnt_q[c] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      if (wr) mem_q[wp_q] <= in_code;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ferr_q  <= !frame_ok;
    end
  end
`ifdef ERR_COUNT_EN
  logic [ERR_W-1:0] err_q, err_d;
  assign err_d = (!frame_ok && err_q != '1) ? err_q + ERR_W'(1) : err_q;
  always_ff @(posedge Clk) begin
    if (Rst) err_q <= '0;
    else     err_q <= err_d;
  end
  assign err_count = err_q;
`endif
  assign {fdoor_act, rdoor_act, alarm_act, win_act, heater_act, cooler_act} =
         {act[0], act[1], act[2], act[3], act[4], act[5]};
  assign evt_valid = count_q != '0;
  assign evt_code  = mem_q[rp_q];
  assign evt_count = count_q;
  assign evt_ovf   = ovf_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_home_event_decoder.sv
// tb_home_event_decoder: timeline-based reference model plus directed and random stimulus.
module tb_home_event_decoder;
  localparam int HOLD  = 10;
  localparam int DEPTH = 4;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [5:0] in_bus = '0;
  logic [2:0] in_code = '0;
  logic evt_ready = 1'b0, ovf_clr = 1'b0;
  logic fdoor_act, rdoor_act, alarm_act, win_act, heater_act, cooler_act;
  logic evt_valid, evt_ovf, frame_err;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
`ifdef ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  home_event_decoder dut (
    .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .in_code(in_code),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr),
    .fdoor_act(fdoor_act), .rdoor_act(rdoor_act), .alarm_act(alarm_act),
    .win_act(win_act), .heater_act(heater_act), .cooler_act(cooler_act),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_count(evt_count),
    .evt_ovf(evt_ovf), .frame_err(frame_err)
`ifdef ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 Clk = ~Clk;
  wire [5:0] act_v = {fdoor_act, rdoor_act, alarm_act, win_act, heater_act, cooler_act};
  int compared = 0, mismatched = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: each channel remembers its last triggering edge and its last interlock cancel edge
  int n = 0;
  int last_t [6];
  int kill_t [6];
  logic [2:0] q [$];
  bit ovf_m, ferr_m, started, m_evt, m_ok, m_push, m_pop, m_drop;
  int errc_m, k, sz;
  function automatic bit active(int c, int t);
    return (t - last_t[c] < HOLD) && (kill_t[c] <= last_t[c]);
  endfunction
  always @(posedge Clk) begin
    n++;
    started = 1;
    if (Rst) begin
      q.delete();
      for (int c = 0; c < 6; c++) begin last_t[c] = -100; kill_t[c] = -100; end
      ovf_m = 0; ferr_m = 0; errc_m = 0;
    end else begin
      k = int'(in_code);
      m_evt = k >= 1 && k <= 6 && in_bus == (6'b1 << (6 - k));
      m_ok = m_evt || (k == 0 && in_bus == 6'd0);
      ferr_m = !m_ok;
      if (!m_ok && errc_m < 255) errc_m++;
      sz = q.size();
      m_pop = sz > 0 && evt_ready;
      m_push = m_evt && !active(k - 1, n - 1);
      if (m_evt) begin
        last_t[k-1] = n;
        if (k == 5) kill_t[5] = n;
        if (k == 6) kill_t[4] = n;
      end
      if (m_pop) void'(q.pop_front());
      m_drop = m_push && sz == DEPTH && !m_pop;
      if (m_push && !m_drop) q.push_back(in_code);
      ovf_m = (ovf_m && !ovf_clr) || m_drop;
    end
  end
  always @(negedge Clk) begin
    if (started) begin
      for (int c = 0; c < 6; c++) chk($sformatf("act%0d", c), act_v[5-c], active(c, n));
      chk("evt_valid", evt_valid, q.size() != 0);
      if (q.size() != 0) chk("evt_code", evt_code, q[0]);
      chk("evt_count", evt_count, q.size());
      chk("evt_ovf", evt_ovf, ovf_m);
      chk("frame_err", frame_err, ferr_m);
`ifdef ERR_COUNT_EN
      chk("err_count", err_count, errc_m);
`endif
    end
  end
  task automatic frame(input int c, input logic [5:0] b, input bit r = 0, input bit clr = 0);
    in_code = 3'(c); in_bus = b; evt_ready = r; ovf_clr = clr;
    @(negedge Clk);
  endtask
  task automatic do_reset();
    Rst = 1; in_code = 0; in_bus = 0; evt_ready = 0; ovf_clr = 0;
    repeat (2) @(negedge Clk);
    Rst = 0;
  endtask
  int hi, low;
  initial begin
    do_reset();
    frame(0, 0);
    chk("rst_act", act_v, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ferr", frame_err, 0);
    frame(1, 6'b100000);
    chk("fd_valid", evt_valid, 1);
    chk("fd_code", evt_code, 1);
    hi = int'(fdoor_act);
    repeat (15) begin frame(0, 0); hi += int'(fdoor_act); end
    chk("fd_hold_len", hi, 10);
    do_reset();
    low = 0;
    repeat (4) begin
      frame(1, 6'b100000);
      low += int'(!fdoor_act);
      repeat (4) begin frame(0, 0); low += int'(!fdoor_act); end
    end
    chk("retrig_low", low, 0);
    chk("retrig_count", evt_count, 1);
    do_reset();
    frame(5, 6'b000010);
    frame(0, 0);
    frame(6, 6'b000001);
    chk("il_heater", heater_act, 0);
    chk("il_cooler", cooler_act, 1);
    chk("il_count", evt_count, 2);
    chk("il_head", evt_code, 5);
    frame(0, 0, 1);
    chk("il_next", evt_code, 6);
    do_reset();
    frame(1, 6'b100000); frame(2, 6'b010000); frame(3, 6'b001000); frame(4, 6'b000100);
    chk("ov_full", evt_count, 4);
    frame(6, 6'b000001);
    chk("ov_flag", evt_ovf, 1);
    chk("ov_count", evt_count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ov_order", evt_code, i);
      frame(0, 0, 1);
    end
    chk("ov_empty", evt_valid, 0);
    frame(0, 0, 0, 1);
    chk("ov_clr", evt_ovf, 0);
    do_reset();
    frame(2, 6'b100000);
    chk("mf_err", frame_err, 1);
    chk("mf_act", act_v, 0);
    chk("mf_valid", evt_valid, 0);
    frame(0, 0);
    chk("mf_pulse", frame_err, 0);
    frame(7, 0);
    chk("mf_code7", frame_err, 1);
`ifdef ERR_COUNT_EN
    chk("mf_errcnt", err_count, 2);
`endif
    do_reset();
    frame(1, 6'b100000); frame(2, 6'b010000); frame(3, 6'b001000); frame(4, 6'b000100);
    frame(5, 6'b000010, 1);
    chk("pp_count", evt_count, 4);
    chk("pp_ovf", evt_ovf, 0);
    for (int i = 2; i <= 4; i++) begin
      chk("pp_order", evt_code, i);
      frame(0, 0, 1);
    end
    chk("pp_tail", evt_code, 5);
    do_reset();
    repeat (4000) begin
      int sel, kk;
      sel = $urandom_range(0, 9);
      kk = $urandom_range(1, 6);
      Rst = ($urandom_range(0, 499) == 0);
      if (sel < 5) frame(0, 0, $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
      else if (sel < 8) frame(kk, 6'b1 << (6 - kk), $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
      else if (sel == 8) frame($urandom_range(0, 7), 6'($urandom_range(0, 63)), $urandom_range(0, 1), 0);
      else frame(7, 6'($urandom_range(0, 63)), $urandom_range(0, 1), 0);
    end
    Rst = 0;
    frame(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
